// File: rtl/systolic_array_4x4.sv
// 4x4 output-stationary systolic matrix multiplier (C = L x R), serial byte load and unload.
// Optional build macro SYSTOLIC_SAT_OUT_EN: results saturate at 2^DATA_W-1 instead of truncating.
module systolic_array_4x4 #(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int ACC_W  = 20
) (
  input  logic              clk_p,
  input  logic              rstn_p,
  input  logic              en_p,
  input  logic [DATA_W-1:0] p_shift_in,
  output logic [DATA_W-1:0] p_shift_out,
  output logic              ack_p
);

`ifdef SYSTOLIC_SAT_OUT_EN
  localparam bit SAT_OUT = 1'b1;
`else
  localparam bit SAT_OUT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_OUTPUT  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]          r_cnt;
  logic [DATA_W-1:0]   r_l   [N][N];
  logic [DATA_W-1:0]   r_r   [N][N];
  logic [DATA_W-1:0]   r_a   [N][N];
  logic [DATA_W-1:0]   r_b   [N][N];
  logic [ACC_W-1:0]    r_acc [N][N];

  logic [3:0]          w_dl     [N];
  logic [3:0]          w_dr     [N];
  logic [DATA_W-1:0]   w_feed_l [N];
  logic [DATA_W-1:0]   w_feed_r [N];
  logic [DATA_W-1:0]   w_a_in   [N][N];
  logic [DATA_W-1:0]   w_b_in   [N][N];
  logic [2*DATA_W-1:0] w_prod   [N][N];

  logic w_load_last;
  logic w_comp_last;
  logic w_out_last;

  assign w_load_last = (r_cnt == 5'd31);
  assign w_comp_last = (r_cnt == 5'd10);
  assign w_out_last  = (r_cnt == 5'd15);

  // Every acc bit is read so the truncating build and the saturating build share one datapath.
  function automatic logic [DATA_W-1:0] f_out_byte(input logic [ACC_W-1:0] acc);
    if (SAT_OUT && (|acc[ACC_W-1:DATA_W])) begin
      f_out_byte = {DATA_W{1'b1}};
    end else begin
      f_out_byte = acc[DATA_W-1:0];
    end
  endfunction

  // State register
  always_ff @(posedge clk_p or negedge rstn_p) begin
    if (!rstn_p) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; dropping en_p mid-load abandons the job
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (en_p) w_next = S_LOAD;
        else      w_next = S_IDLE;
      end
      S_LOAD: begin
        if (!en_p)            w_next = S_IDLE;
        else if (w_load_last) w_next = S_COMPUTE;
        else                  w_next = S_LOAD;
      end
      S_COMPUTE: begin
        if (w_comp_last) w_next = S_OUTPUT;
        else             w_next = S_COMPUTE;
      end
      S_OUTPUT: begin
        if (w_out_last) w_next = S_DONE;
        else            w_next = S_OUTPUT;
      end
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Phase counter: capture index, compute cycle, or output index
  always_ff @(posedge clk_p or negedge rstn_p) begin
    if (!rstn_p) begin
      r_cnt <= 5'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (!en_p || w_load_last) r_cnt <= 5'd0;
          else                      r_cnt <= r_cnt + 5'd1;
        end
        S_COMPUTE: begin
          if (w_comp_last) r_cnt <= 5'd0;
          else             r_cnt <= r_cnt + 5'd1;
        end
        S_OUTPUT: begin
          if (w_out_last) r_cnt <= 5'd0;
          else            r_cnt <= r_cnt + 5'd1;
        end
        default: r_cnt <= 5'd0;
      endcase
    end
  end

  // Operand capture: L rows arrive column 3 first, R columns arrive row 3 first
  always_ff @(posedge clk_p or negedge rstn_p) begin
    if (!rstn_p) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_l[i][j] <= {DATA_W{1'b0}};
          r_r[i][j] <= {DATA_W{1'b0}};
        end
      end
    end else if ((r_state == S_LOAD) && en_p) begin
      if (!r_cnt[4]) r_l[r_cnt[3:2]][~r_cnt[1:0]] <= p_shift_in;
      else           r_r[~r_cnt[1:0]][r_cnt[3:2]] <= p_shift_in;
    end
  end

  // Skewed edge feed: row i / column j see element (t - i) / (t - j), zero outside the window
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_dl[i]     = r_cnt[3:0] - 4'(i);
      w_dr[i]     = r_cnt[3:0] - 4'(i);
      w_feed_l[i] = {DATA_W{1'b0}};
      w_feed_r[i] = {DATA_W{1'b0}};
      if ((r_state == S_COMPUTE) && (r_cnt[3:0] >= 4'(i)) && (w_dl[i] < 4'd4)) begin
        w_feed_l[i] = r_l[i][w_dl[i][1:0]];
        w_feed_r[i] = r_r[w_dr[i][1:0]][i];
      end else begin
        w_feed_l[i] = {DATA_W{1'b0}};
        w_feed_r[i] = {DATA_W{1'b0}};
      end
    end
  end

  // PE operand routing and products
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a_in[i][0] = w_feed_l[i];
      w_b_in[0][i] = w_feed_r[i];
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 1; j < N; j++) begin
        w_a_in[i][j] = r_a[i][j-1];
        w_b_in[j][i] = r_b[j-1][i];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_prod[i][j] = {{DATA_W{1'b0}}, w_a_in[i][j]} * {{DATA_W{1'b0}}, w_b_in[i][j]};
      end
    end
  end

  // PE grid: accumulate and forward operands; IDLE clears it for the next job
  always_ff @(posedge clk_p or negedge rstn_p) begin
    if (!rstn_p) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_acc[i][j] <= {ACC_W{1'b0}};
          r_a[i][j]   <= {DATA_W{1'b0}};
          r_b[i][j]   <= {DATA_W{1'b0}};
        end
      end
    end else if (r_state == S_IDLE) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_acc[i][j] <= {ACC_W{1'b0}};
          r_a[i][j]   <= {DATA_W{1'b0}};
          r_b[i][j]   <= {DATA_W{1'b0}};
        end
      end
    end else if (r_state == S_COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_acc[i][j] <= r_acc[i][j] + {{(ACC_W-2*DATA_W){1'b0}}, w_prod[i][j]};
          r_a[i][j]   <= w_a_in[i][j];
          r_b[i][j]   <= w_b_in[i][j];
        end
      end
    end
  end

  // Registered result stream, row-major
  always_ff @(posedge clk_p or negedge rstn_p) begin
    if (!rstn_p) begin
      p_shift_out <= {DATA_W{1'b0}};
      ack_p       <= 1'b0;
    end else if (r_state == S_OUTPUT) begin
      p_shift_out <= f_out_byte(r_acc[r_cnt[3:2]][r_cnt[1:0]]);
      ack_p       <= 1'b1;
    end else begin
      p_shift_out <= {DATA_W{1'b0}};
      ack_p       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Directed bench for systolic_array_4x4 with a result scoreboard and latency/window checks.
module tb_systolic_array_4x4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       ack;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_ack  = 0;
  int first_cyc;
  int last_cyc;
  int c32;
  bit got_first;

  logic [7:0] sb [$];
  logic [7:0] lm [4][4];
  logic [7:0] rm [4][4];

  systolic_array_4x4 dut (
    .clk_p      (clk),
    .rstn_p     (rstn),
    .en_p       (en),
    .p_shift_in (din),
    .p_shift_out(dout),
    .ack_p      (ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every ack cycle must match the oldest expected byte
  always @(negedge clk) begin
    if (rstn === 1'b1 && ack === 1'b1) begin
      logic [7:0] e;
      if (!got_first) begin
        first_cyc = cyc;
        got_first = 1'b1;
      end
      last_cyc = cyc;
      n_ack++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_ack observed=%0d required=0 (queue empty)", ack);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        assert (dout === e) else begin
          errors++;
          $error("FAIL result observed=%0d required=%0d", dout, e);
        end
      end
    end
  end

  task automatic push_expected();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int acc;
        logic [31:0] a32;
        acc = 0;
        for (int k = 0; k < 4; k++) acc += int'(lm[i][k]) * int'(rm[k][j]);
        a32 = acc;
`ifdef SYSTOLIC_SAT_OUT_EN
        sb.push_back((acc > 255) ? 8'd255 : a32[7:0]);
`else
        sb.push_back(a32[7:0]);
`endif
      end
    end
  endtask

  task automatic load(input int abort_at);
    @(negedge clk);
    en  = 1'b1;
    din = 8'd0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        en  = 1'b0;
        din = 8'd0;
        @(negedge clk);
        return;
      end
      if (k < 16) din = lm[k/4][3 - (k%4)];
      else        din = rm[3 - ((k-16)%4)][(k-16)/4];
    end
    @(negedge clk);
    c32 = cyc;
    en  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rstn = 1'b0;
    en   = 1'b0;
    #1;
    checks++;
    assert (ack === 1'b0) else begin
      errors++;
      $error("FAIL %s_ack observed=%0d required=0", tag, ack);
    end
    checks++;
    assert (dout === 8'd0) else begin
      errors++;
      $error("FAIL %s_out observed=%0d required=0", tag, dout);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_job(input string tag);
    int base;
    base      = n_ack;
    got_first = 1'b0;
    push_expected();
    load(32);
    for (int c = 0; c < 100 && (n_ack - base) < 16; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    assert ((n_ack - base) === 16) else begin
      errors++;
      $error("FAIL %s_ack_count observed=%0d required=16", tag, n_ack - base);
    end
    checks++;
    assert (got_first && (first_cyc - c32) === 12) else begin
      errors++;
      $error("FAIL %s_latency observed=%0d required=12", tag, first_cyc - c32);
    end
    checks++;
    assert ((last_cyc - first_cyc) === 15) else begin
      errors++;
      $error("FAIL %s_window observed=%0d required=15", tag, last_cyc - first_cyc);
    end
    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL %s_leftover observed=%0d required=0", tag, sb.size());
    end
    // DONE must hold quiet even with en_p asserted
    en = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    assert (ack === 1'b0 && dout === 8'd0 && (n_ack - base) === 16) else begin
      errors++;
      $error("FAIL %s_done_hold observed=%0d/%0d required=0/0", tag, ack, dout);
    end
    en = 1'b0;
  endtask

  task automatic expect_silent(input string tag, input int cycles);
    int base;
    base = n_ack;
    repeat (cycles) @(negedge clk);
    checks++;
    assert ((n_ack - base) === 0) else begin
      errors++;
      $error("FAIL %s_no_output observed=%0d required=0", tag, n_ack - base);
    end
  endtask

  task automatic set_case(input int id);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        case (id)
          1: begin
            lm[i][j] = 8'(j + 1);
            rm[i][j] = 8'(i + 1);
          end
          2: begin
            lm[i][j] = (i == 0 || i == 3 || j == 0 || j == 3) ? 8'd1 : 8'd0;
            rm[i][j] = 8'(2*(4*i + j) + 12);
          end
          3: begin
            lm[i][j] = 8'(3*(4*i + j));
            rm[i][j] = (i == j) ? 8'd2 : ((i + j == 3) ? 8'd1 : 8'd0);
          end
          default: begin
            lm[i][j] = 8'd255;
            rm[i][j] = 8'd255;
          end
        endcase
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    en   = 1'b0;
    din  = 8'd0;
    do_reset("reset0");

    set_case(1);
    run_job("case1");
    do_reset("reset1");

    set_case(2);
    run_job("case2");
    do_reset("reset2");

    set_case(3);
    run_job("case3");
    do_reset("reset3");

    set_case(4);
    run_job("case4");
    do_reset("reset4");

    // Reset in the middle of COMPUTE: no output, then a clean job
    set_case(3);
    load(32);
    repeat (5) @(negedge clk);
    do_reset("mid_compute");
    expect_silent("mid_compute", 70);
    set_case(2);
    run_job("after_reset");
    do_reset("reset5");

    // en_p dropped at capture 10: back to IDLE, next full load works without a reset
    set_case(1);
    load(10);
    expect_silent("en_abort", 70);
    set_case(3);
    run_job("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
